// File: rtl/mac_input_ctrl.sv
// Operator-entry sequencer: latches A then B from the switches on next_pulse and offers them to the MAC.
// Outputs registered, 1-cycle reaction; operands held while mac_ready is low, entry stalls at MAX_OPS until clr_pulse.
module mac_input_ctrl #(
    parameter int  DATA_W  = 8,
    parameter int  MAX_OPS = 16,
    localparam int CNT_W   = $clog2(MAX_OPS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              next_pulse,
    input  logic              clr_pulse,
    input  logic [DATA_W-1:0] sw,
    input  logic              mac_ready,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_valid,
    output logic              mac_clr,
    output logic [CNT_W-1:0]  op_count,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        S_CAP_A = 3'd0,
        S_CAP_B = 3'd1,
        S_ISSUE = 3'd2,
        S_CLEAR = 3'd3,
        S_FULL  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

    state_t            r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_valid;
    logic              r_clr;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_hs;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_hs      = r_valid && mac_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CAP_A;
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
            r_clr   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_clr <= 1'b0;
            // Clear overrides everything, including a handshake completing this cycle.
            if (clr_pulse) begin
                r_state <= S_CLEAR;
                r_clr   <= 1'b1;
                r_valid <= 1'b0;
                r_cnt   <= '0;
                r_a     <= '0;
                r_b     <= '0;
            end else begin
                unique case (r_state)
                    S_CAP_A: begin
                        if (next_pulse) begin
                            r_a     <= sw;
                            r_state <= S_CAP_B;
                        end
                    end
                    S_CAP_B: begin
                        if (next_pulse) begin
                            r_b     <= sw;
                            r_valid <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (w_hs) begin
                            r_valid <= 1'b0;
                            r_cnt   <= w_cnt_inc;
                            r_state <= (w_cnt_inc == MAX_CNT) ? S_FULL : S_CAP_A;
                        end
                    end
                    S_CLEAR: r_state <= S_CAP_A;
                    S_FULL:  r_state <= S_FULL;
                    default: r_state <= S_CAP_A;
                endcase
            end
        end
    end

    assign mac_a     = r_a;
    assign mac_b     = r_b;
    assign mac_valid = r_valid;
    assign mac_clr   = r_clr;
    assign op_count  = r_cnt;
    assign state_o   = r_state;

endmodule

// File: tb/tb_mac_input_ctrl.sv
// Randomized bench for mac_input_ctrl: operator-level model plus a handshake scoreboard.
module tb_mac_input_ctrl;

    localparam int DATA_W  = 8;
    localparam int MAX_OPS = 16;
    localparam int CNT_W   = $clog2(MAX_OPS + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              next_pulse;
    logic              clr_pulse;
    logic [DATA_W-1:0] sw;
    logic              mac_ready;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic              mac_valid;
    logic              mac_clr;
    logic [CNT_W-1:0]  op_count;
    logic [2:0]        state_o;

    mac_input_ctrl #(.DATA_W(DATA_W), .MAX_OPS(MAX_OPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .next_pulse (next_pulse),
        .clr_pulse  (clr_pulse),
        .sw         (sw),
        .mac_ready  (mac_ready),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_valid  (mac_valid),
        .mac_clr    (mac_clr),
        .op_count   (op_count),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Operator view: which step the panel is waiting for, what has been entered, ops done.
    localparam int P_WANT_A = 0, P_WANT_B = 1, P_AT_MAC = 2, P_CLEARING = 3, P_LIMIT = 4;
    int              m_phase;
    logic [7:0]      m_a, m_b;
    int              m_ops;
    bit              m_clr;
    logic [15:0]     exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Predict what the panel shows after the coming clock edge.
    task automatic model_step(input bit r, input bit n, input bit c, input bit rdy, input logic [7:0] s);
        if (r) begin
            m_phase = P_WANT_A; m_a = 0; m_b = 0; m_ops = 0; m_clr = 0;
            return;
        end
        if (m_phase == P_AT_MAC && rdy) exp_q.push_back({m_a, m_b});
        m_clr = 0;
        if (c) begin
            m_phase = P_CLEARING; m_clr = 1; m_ops = 0; m_a = 0; m_b = 0;
        end else if (m_phase == P_WANT_A && n) begin
            m_a = s; m_phase = P_WANT_B;
        end else if (m_phase == P_WANT_B && n) begin
            m_b = s; m_phase = P_AT_MAC;
        end else if (m_phase == P_AT_MAC && rdy) begin
            m_ops++;
            m_phase = (m_ops == MAX_OPS) ? P_LIMIT : P_WANT_A;
        end else if (m_phase == P_CLEARING) begin
            m_phase = P_WANT_A;
        end
    endtask

    task automatic cyc(input bit n, input bit c, input bit rdy, input logic [7:0] s, input bit r = 0);
        rst = r; next_pulse = n; clr_pulse = c; mac_ready = rdy; sw = s;
        model_step(r, n, c, rdy, s);
        @(posedge clk);
        #1;
        check("state_o", 32'(state_o), 32'(m_phase));
        check("op_count", 32'(op_count), 32'(m_ops));
        check("mac_valid", 32'(mac_valid), 32'(m_phase == P_AT_MAC));
        check("mac_clr", 32'(mac_clr), 32'(m_clr));
        check("mac_a", 32'(mac_a), 32'(m_a));
        check("mac_b", 32'(mac_b), 32'(m_b));
    endtask

    // Every handshake the DUT presents must match the next operand pair the model released.
    always @(negedge clk) begin
        if (rst === 1'b0 && mac_valid === 1'b1 && mac_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL handshake_unexpected actual=%0h%0h expected=none t=%0t", mac_a, mac_b, $time);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({mac_a, mac_b} !== e) begin
                    failures++;
                    $display("FAIL handshake_ops actual=%0h expected=%0h t=%0t", {mac_a, mac_b}, e, $time);
                end
            end
        end
    end

    task automatic enter_op(input logic [7:0] a, input logic [7:0] b);
        cyc(1, 0, 0, a);
        cyc(1, 0, 0, b);
    endtask

    initial begin
        rst = 1; next_pulse = 0; clr_pulse = 0; mac_ready = 0; sw = 0;
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00);

        // Basic operation
        enter_op(8'h12, 8'h34);
        cyc(0, 0, 1, 8'h00);
        check("t1_count", 32'(op_count), 1);
        check("t1_state", 32'(state_o), 0);
        check("t1_a", 32'(mac_a), 32'h12);

        // Stall with ignored next pulse
        enter_op(8'h56, 8'h78);
        for (int i = 0; i < 5; i++) cyc(i == 2, 0, 0, 8'hFF);
        check("t2_b_held", 32'(mac_b), 32'h78);
        cyc(0, 0, 1, 8'h00);
        check("t2_count", 32'(op_count), 2);

        // Fill to the limit with random operands and random MAC stalls
        cyc(0, 1, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        for (int k = 0; k < MAX_OPS; k++) begin
            enter_op(8'($urandom), 8'($urandom));
            for (int d = int'($urandom_range(0, 3)); d > 0; d--) cyc(0, 0, 0, 8'h00);
            cyc(0, 0, 1, 8'h00);
        end
        check("t3_full_count", 32'(op_count), MAX_OPS);
        check("t3_full_state", 32'(state_o), 4);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 8'hAA);
        check("t3_still_full", 32'(state_o), 4);
        cyc(0, 1, 0, 8'h00);
        check("t3_clr_strobe", 32'(mac_clr), 1);
        cyc(0, 0, 0, 8'h00);
        check("t3_clr_once", 32'(mac_clr), 0);
        check("t3_after_state", 32'(state_o), 0);

        // Clear and next together in CAP_B
        cyc(1, 0, 0, 8'h11);
        cyc(1, 1, 0, 8'h22);
        check("t4_b_zero", 32'(mac_b), 0);
        cyc(0, 0, 1, 8'h00);
        check("t4_no_valid", 32'(mac_valid), 0);

        // Clear on the handshake cycle
        enter_op(8'h01, 8'h02);
        cyc(0, 1, 1, 8'h00);
        check("t5_count", 32'(op_count), 0);
        check("t5_clr", 32'(mac_clr), 1);
        cyc(0, 0, 0, 8'h00);

        // Reset during ISSUE
        enter_op(8'h9A, 8'hBC);
        check("t6_valid_pre", 32'(mac_valid), 1);
        cyc(0, 0, 0, 8'h00, 1);
        check("t6_valid", 32'(mac_valid), 0);
        check("t6_clr", 32'(mac_clr), 0);
        cyc(0, 0, 0, 8'h00);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
                $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 299) == 0);
        end
        cyc(0, 0, 0, 8'h00);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
